// File: rtl/sipo_deserializer_pkg.sv
//------------------------------------------------------------------------------
// Module : sipo_deserializer_pkg
// Brief  : Shared bit-order constants and sizing helper for the serial link.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sipo_deserializer_pkg;

  // The PISO transmitter uses the same encoding, so both ends agree on bit order.
  localparam int ORDER_MSB_FIRST = 1;
  localparam int ORDER_LSB_FIRST = 0;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : sipo_deserializer_pkg

`default_nettype wire

// File: rtl/sipo_deserializer_shift_core.sv
//------------------------------------------------------------------------------
// Module : sipo_shift_core
// Brief  : Shift register plus bit counter; pulses word_done on the last bit.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sipo_shift_core
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = ORDER_MSB_FIRST,
  localparam int CW       = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] shreg,
  output logic [CW-1:0]    bit_cnt,
  output logic             word_done,
  output logic [WIDTH-1:0] word
);

  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] w_shift_next;
  logic             w_word_end;

  generate
    if (MSB_FIRST == ORDER_MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shreg[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign w_shift_next = {sin, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign w_word_end = (r_bit_cnt == c_last);
  // A sync bit always starts a fresh word, so it can never complete one.
  assign word_done  = sin_valid & ~sync & w_word_end;
  assign word       = w_shift_next;
  assign shreg      = r_shreg;
  assign bit_cnt    = r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (sin_valid) begin
      r_shreg <= w_shift_next;
      if (sync) begin
        r_bit_cnt <= CW'(1);
      end else if (w_word_end) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end else if (sync) begin
      r_bit_cnt <= '0;
    end
  end

endmodule : sipo_shift_core

`default_nettype wire

// File: rtl/sipo_deserializer.sv
//------------------------------------------------------------------------------
// Module : sipo_deserializer
// Brief  : Serial-in/parallel-out receiver with valid/ready word port and overrun flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = ORDER_MSB_FIRST,
  localparam int CW       = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic [WIDTH-1:0] Q_all,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  logic [WIDTH-1:0] w_word;
  logic             w_word_done;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] r_par_out;
  logic             r_par_valid;
  logic             r_overrun;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync      (sync),
    .shreg     (Q_all),
    .bit_cnt   (bit_cnt),
    .word_done (w_word_done),
    .word      (w_word)
  );

  // Loading while the held word is being consumed keeps par_valid high with no bubble.
  assign w_load = w_word_done & (~r_par_valid | par_ready);
  assign w_drop = w_word_done & r_par_valid & ~par_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_out   <= '0;
      r_par_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_par_out   <= w_word;
        r_par_valid <= 1'b1;
      end else if (par_ready) begin
        r_par_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign par_out   = r_par_out;
  assign par_valid = r_par_valid;
  assign overrun   = r_overrun;

endmodule : sipo_deserializer

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
//------------------------------------------------------------------------------
// Module : tb_sipo_deserializer
// Brief  : Self-checking bench: vector table, bit-order and loopback sequences,
//          randomized traffic against a bit-queue reference model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_deserializer;

  localparam int W  = 4;
  localparam int CW = 2;

  typedef struct {
    logic         sin;
    logic         vld;
    logic         syn;
    logic         rdy;
    logic         clr;
    logic         ev;
    logic [W-1:0] eo;
    logic         eovr;
    logic [CW-1:0] ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          sin, sin_valid, sync, par_ready, ovr_clr;
  logic [W-1:0]  par_out, q_all;
  logic          par_valid, overrun;
  logic [CW-1:0] bit_cnt;

  logic          b_sin, b_sin_valid, b_sync, b_par_ready, b_ovr_clr;
  logic [W-1:0]  b_par_out, b_q_all;
  logic          b_par_valid, b_overrun;
  logic [CW-1:0] b_bit_cnt;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sync(sync),
    .par_out(par_out), .par_valid(par_valid), .par_ready(par_ready),
    .Q_all(q_all), .bit_cnt(bit_cnt), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .sin(b_sin), .sin_valid(b_sin_valid), .sync(b_sync),
    .par_out(b_par_out), .par_valid(b_par_valid), .par_ready(b_par_ready),
    .Q_all(b_q_all), .bit_cnt(b_bit_cnt), .overrun(b_overrun), .ovr_clr(b_ovr_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bits of the word in progress, last W bits ever received, output slot.
  logic         cur[$];
  logic         hist[$];
  logic         m_valid;
  logic [W-1:0] m_out;
  logic         m_ovr;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_out   = '0;
    m_ovr   = 1'b0;
    cur.delete();
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
  endtask

  function automatic logic [W-1:0] model_q();
    logic [W-1:0] q;
    for (int i = 0; i < W; i++) q[i] = hist[hist.size() - 1 - i];
    return q;
  endfunction

  task automatic model_update();
    logic         done;
    logic         drop;
    logic [W-1:0] word;
    done = 1'b0;
    drop = 1'b0;
    word = '0;
    if (sin_valid) begin
      hist.push_back(sin);
      void'(hist.pop_front());
      if (sync) cur.delete();
      cur.push_back(sin);
      if (cur.size() == W) begin
        for (int i = 0; i < W; i++) word[W-1-i] = cur[i];
        done = 1'b1;
        cur.delete();
      end
    end else if (sync) begin
      cur.delete();
    end
    if (done) begin
      if (!m_valid || par_ready) begin
        m_valid = 1'b1;
        m_out   = word;
      end else begin
        drop = 1'b1;
      end
    end else if (par_ready) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".par_out"},   32'(par_out),   32'(m_out));
    chk({tag, ".par_valid"}, 32'(par_valid), 32'(m_valid));
    chk({tag, ".Q_all"},     32'(q_all),     32'(model_q()));
    chk({tag, ".bit_cnt"},   32'(bit_cnt),   32'(cur.size()));
    chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
  endtask

  task automatic drive(input logic s, input logic v, input logic y, input logic r, input logic c);
    sin = s; sin_valid = v; sync = y; par_ready = r; ovr_clr = c;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic add(input logic s, input logic v, input logic y, input logic r, input logic c,
                     input logic ev, input logic [W-1:0] eo, input logic eovr, input logic [CW-1:0] ecnt);
    vec_t t;
    t.sin = s; t.vld = v; t.syn = y; t.rdy = r; t.clr = c;
    t.ev = ev; t.eo = eo; t.eovr = eovr; t.ecnt = ecnt;
    tbl.push_back(t);
  endtask

  task automatic b_bit(input logic s, input logic [W-1:0] exp_q);
    b_sin = s; b_sin_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_sin_valid = 1'b0;
    chk("lsb.Q_all", 32'(b_q_all), 32'(exp_q));
  endtask

  initial begin
    logic [W-1:0] piso;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    b_sin = 0; b_sin_valid = 0; b_sync = 0; b_par_ready = 1; b_ovr_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_model("reset");

    // Bits 1010 (ready=1), then ready=0 overrun scenario, sync/gap handling, no-bubble reload.
    add(1,1,0,1,0, 0,4'h0,0,1); add(0,1,0,1,0, 0,4'h0,0,2);
    add(1,1,0,1,0, 0,4'h0,0,3); add(0,1,0,1,0, 1,4'hA,0,0);
    add(0,0,0,1,0, 0,4'hA,0,0);
    add(1,1,0,0,0, 0,4'hA,0,1); add(0,1,0,0,0, 0,4'hA,0,2);
    add(1,1,0,0,0, 0,4'hA,0,3); add(0,1,0,0,0, 1,4'hA,0,0);
    add(1,1,0,0,0, 1,4'hA,0,1); add(1,1,0,0,0, 1,4'hA,0,2);
    add(0,1,0,0,0, 1,4'hA,0,3); add(0,1,0,0,0, 1,4'hA,1,0);
    add(0,0,0,1,0, 0,4'hA,1,0); add(0,0,0,0,1, 0,4'hA,0,0);
    add(1,1,0,1,0, 0,4'hA,0,1); add(1,1,0,1,0, 0,4'hA,0,2);
    add(0,1,1,1,0, 0,4'hA,0,1); add(1,0,0,1,0, 0,4'hA,0,1);
    add(1,1,0,1,0, 0,4'hA,0,2); add(0,0,0,1,0, 0,4'hA,0,2);
    add(1,1,0,1,0, 0,4'hA,0,3); add(0,1,0,1,0, 1,4'h6,0,0);
    add(1,1,0,0,0, 1,4'h6,0,1); add(0,0,1,0,0, 1,4'h6,0,0);
    add(1,1,0,0,0, 1,4'h6,0,1); add(0,1,0,0,0, 1,4'h6,0,2);
    add(0,1,0,0,0, 1,4'h6,0,3); add(1,1,0,1,0, 1,4'h9,0,0);
    add(1,1,0,0,0, 1,4'h9,0,1); add(1,1,0,0,0, 1,4'h9,0,2);
    add(1,1,0,0,0, 1,4'h9,0,3); add(1,1,0,0,1, 1,4'h9,1,0);
    add(0,0,0,1,1, 0,4'h9,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].sin, tbl[i].vld, tbl[i].syn, tbl[i].rdy, tbl[i].clr);
      step();
      chk($sformatf("vec%0d.par_valid", i), 32'(par_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.par_out", i),   32'(par_out),   32'(tbl[i].eo));
      chk($sformatf("vec%0d.overrun", i),   32'(overrun),   32'(tbl[i].eovr));
      chk($sformatf("vec%0d.bit_cnt", i),   32'(bit_cnt),   32'(tbl[i].ecnt));
      check_model($sformatf("vec%0d.model", i));
    end
    drive(0, 0, 0, 0, 0);

    // LSB-first instance: Q_all right-shifts, first bit ends up in par_out[0].
    b_bit(1'b1, 4'b1000);
    b_bit(1'b0, 4'b0100);
    chk("lsb.par_valid_mid", 32'(b_par_valid), 32'(0));
    b_bit(1'b1, 4'b1010);
    b_bit(1'b0, 4'b0101);
    chk("lsb.par_out",   32'(b_par_out),   32'(4'b0101));
    chk("lsb.par_valid", 32'(b_par_valid), 32'(1));

    // Loopback from a behavioural PISO loaded with 1010.
    piso = 4'b1010;
    for (int i = 0; i < W; i++) begin
      drive(piso[W-1], 1, 0, 1, 0);
      piso = {piso[W-2:0], 1'b0};
      step();
      check_model("loop");
    end
    chk("loop.par_out", 32'(par_out), 32'(4'b1010));
    chk("loop.overrun", 32'(overrun), 32'(0));

    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      step();
      check_model("rand");
    end

    // Asynchronous reset away from any clock edge.
    drive(1, 1, 0, 0, 0);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    chk("async_rst.lsb_q",     32'(b_q_all),     32'(0));
    chk("async_rst.lsb_valid", 32'(b_par_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int n = 0; n < 200; n++) begin
      drive(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      step();
      check_model("rand2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sipo_deserializer

`default_nettype wire
